// File: rtl/branch_predict_unit_pkg.sv
// ============================================================================
// Module      : branch_predict_unit_pkg
// Description : Shared encodings, constants and the 2-bit saturating counter
//               update used by the branch predict unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predict_unit_pkg;

  // 2-bit direction counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strong not-taken
    WNT = 2'b01,  // weak not-taken
    WT  = 2'b10,  // weak taken
    ST  = 2'b11   // strong taken
  } cnt_e;

  // Sequential fetch step in bytes
  localparam int unsigned PC_INC = 4;

  // Saturating counter step: count up on taken, down on not-taken
  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == ST) ? ST : cnt + 2'd1;
    end else begin
      nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predict_unit_sat_counter_2b.sv
// ============================================================================
// Module      : sat_counter_2b
// Description : Combinational next-state of a 2-bit saturating direction
//               counter given the resolved branch direction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter_2b
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  // Pure lookup of the saturating step
  assign cnt_o = sat_cnt_next(cnt_i, taken_i);

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module      : branch_predict_unit
// Description : Direct-mapped BTB with 2-bit counters. Same-cycle prediction
//               for the fetch PC, resolution/update from execute, registered
//               misprediction redirect and saturating mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] fetch_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              res_valid_i,
  input  logic [ADDR_W-1:0] res_pc_i,
  input  logic              res_taken_i,
  input  logic [ADDR_W-1:0] res_target_i,
  input  logic              res_pred_taken_i,
  input  logic [ADDR_W-1:0] res_pred_target_i,
  input  logic              flush_btb_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  // Table storage
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         cnt_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];

  // Redirect / statistics state
  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  mispred_count_q, mispred_count_d;

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0]  f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic              f_hit;
  logic              f_taken;

  assign f_idx   = fetch_pc_i[IDX_W+1:2];
  assign f_tag   = fetch_pc_i[ADDR_W-1:IDX_W+2];
  assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken = f_hit && cnt_q[f_idx][1];

  assign pred_hit_o    = f_hit;
  assign pred_taken_o  = f_taken;
  assign pred_target_o = f_taken ? tgt_q[f_idx] : (fetch_pc_i + PC_STEP);

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_hit;
  logic [1:0]        cnt_upd;
  logic              mispred;
  logic [ADDR_W-1:0] correct_pc;

  assign r_idx = res_pc_i[IDX_W+1:2];
  assign r_tag = res_pc_i[ADDR_W-1:IDX_W+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  sat_counter_2b u_sat_counter (
    .cnt_i   (cnt_q[r_idx]),
    .taken_i (res_taken_i),
    .cnt_o   (cnt_upd)
  );

  assign mispred = res_valid_i &&
                   ((res_taken_i != res_pred_taken_i) ||
                    (res_taken_i && (res_target_i != res_pred_target_i)));
  assign correct_pc = res_taken_i ? res_target_i : (res_pc_i + PC_STEP);

  // Next-state for the redirect register and the saturating statistics counter
  always_comb begin
    redirect_valid_d = mispred;
    redirect_pc_d    = redirect_pc_q;
    mispred_count_d  = mispred_count_q;
    if (mispred) begin
      redirect_pc_d = correct_pc;
      if (mispred_count_q != {CNT_W{1'b1}}) begin
        mispred_count_d = mispred_count_q + 1'b1;
      end
    end
  end

  // Valid bits and counters: reset/flush clear, resolution updates or allocates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (flush_btb_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (res_valid_i) begin
      if (r_hit) begin
        cnt_q[r_idx] <= cnt_upd;
      end else if (res_taken_i) begin
        valid_q[r_idx] <= 1'b1;
        cnt_q[r_idx]   <= WT;
      end
    end
  end

  // Tag and target: written on any taken resolution (hit retarget or allocation);
  // contents are meaningless while the valid bit is clear, so no reset needed
  always_ff @(posedge clk_i) begin
    if (res_valid_i && !flush_btb_i && res_taken_i) begin
      tag_q[r_idx] <= r_tag;
      tgt_q[r_idx] <= res_target_i;
    end
  end

  // Redirect pulse, held redirect PC and mispredict count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mispred_count_q  <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mispred_count_q  <= mispred_count_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mispred_count_o  = mispred_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit: directed vector
//               table, hand sequences for saturation and async reset, and a
//               randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        res_valid, res_taken, res_pred_taken, flush_btb;
  logic [31:0] res_pc, res_target, res_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] mispred_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predict_unit #(.ADDR_W(32), .ENTRIES(16), .CNT_W(16)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .fetch_pc_i        (fetch_pc),
    .pred_hit_o        (pred_hit),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .res_valid_i       (res_valid),
    .res_pc_i          (res_pc),
    .res_taken_i       (res_taken),
    .res_target_i      (res_target),
    .res_pred_taken_i  (res_pred_taken),
    .res_pred_target_i (res_pred_target),
    .flush_btb_i       (flush_btb),
    .redirect_valid_o  (redirect_valid),
    .redirect_pc_o     (redirect_pc),
    .mispred_count_o   (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fetch_pc;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        fl;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic [15:0] e_mc;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(
      input logic [31:0] f, input logic rv, input logic [31:0] rpc, input logic rt,
      input logic [31:0] rtgt, input logic pt, input logic [31:0] ptgt, input logic fl,
      input logic eh, input logic et, input logic [31:0] etgt,
      input logic erv, input logic [31:0] erpc, input logic [15:0] emc);
    vec_t v;
    v.fetch_pc = f;  v.rv = rv;   v.rpc = rpc;   v.rt = rt;     v.rtgt = rtgt;
    v.pt = pt;       v.ptgt = ptgt; v.fl = fl;   v.e_hit = eh;  v.e_taken = et;
    v.e_tgt = etgt;  v.e_rv = erv; v.e_rpc = erpc; v.e_mc = emc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector (called at posedge+1), check lookup before the edge,
  // then check registered outputs just after it.
  task automatic apply(input vec_t v);
    fetch_pc = v.fetch_pc; res_valid = v.rv; res_pc = v.rpc; res_taken = v.rt;
    res_target = v.rtgt; res_pred_taken = v.pt; res_pred_target = v.ptgt; flush_btb = v.fl;
    #2;
    chk("pred_hit",    64'(pred_hit),    64'(v.e_hit));
    chk("pred_taken",  64'(pred_taken),  64'(v.e_taken));
    chk("pred_target", 64'(pred_target), 64'(v.e_tgt));
    @(posedge clk); #1;
    chk("redirect_valid", 64'(redirect_valid), 64'(v.e_rv));
    chk("redirect_pc",    64'(redirect_pc),    64'(v.e_rpc));
    chk("mispred_count",  64'(mispred_count),  64'(v.e_mc));
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; res_pred_target = '0; flush_btb = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    fetch_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ------------------------------------------------ behavioural reference
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  logic [31:0] m_rpc;
  int          m_mc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_cnt[i] = 1; end
    m_rpc = '0; m_mc = 0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic h, output logic t,
                            output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) % 16);
    h  = m_valid[i] && (m_tag[i] == (pc >> 6));
    t  = h && (m_cnt[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endtask

  // Fill expected fields of v from the model, then advance the model one edge
  task automatic model_step(input vec_t vi, output vec_t vo);
    bit mis;
    int i;
    vo = vi;
    model_pred(vi.fetch_pc, vo.e_hit, vo.e_taken, vo.e_tgt);
    mis = vi.rv && ((vi.rt != vi.pt) || (vi.rt && vi.rtgt != vi.ptgt));
    if (mis) begin
      m_rpc = vi.rt ? vi.rtgt : vi.rpc + 32'd4;
      if (m_mc < 65535) m_mc++;
    end
    vo.e_rv = mis; vo.e_rpc = m_rpc; vo.e_mc = 16'(m_mc);
    if (vi.fl) begin
      for (int k = 0; k < 16; k++) begin m_valid[k] = 0; m_cnt[k] = 1; end
    end else if (vi.rv) begin
      i = int'((vi.rpc >> 2) % 16);
      if (m_valid[i] && m_tag[i] == (vi.rpc >> 6)) begin
        if (vi.rt) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = vi.rtgt;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (vi.rt) begin
        m_valid[i] = 1; m_tag[i] = vi.rpc >> 6; m_tgt[i] = vi.rtgt; m_cnt[i] = 2;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    if ($urandom_range(0, 9) == 0) r = $urandom();
    else r = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
    if ($urandom_range(0, 9) == 0) r[1:0] = 2'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    vec_t v, w;
    logic ph, pt;
    logic [31:0] ptg;

    tbl[0]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h44,  0, 32'h0,   16'd0);
    tbl[1]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 0, 0, 32'h44,  1, 32'h100, 16'd1);
    tbl[2]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h100, 0, 32'h100, 16'd1);
    tbl[3]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 1, 1, 32'h100, 1, 32'h44,  16'd2);
    tbl[4]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 1, 0, 32'h44,  1, 32'h44,  16'd3);
    tbl[5]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h44,  0, 32'h44,  16'd3);
    tbl[6]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 1, 0, 32'h44,  1, 32'h100, 16'd4);
    tbl[7]  = mk(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84,  0, 0, 0, 32'h84,  1, 32'h200, 16'd5);
    tbl[8]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h44,  0, 32'h200, 16'd5);
    tbl[9]  = mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h200, 0, 32'h200, 16'd5);
    tbl[10] = mk(32'h80, 1, 32'h80, 1, 32'h200, 1, 32'h200, 0, 1, 1, 32'h200, 0, 32'h200, 16'd5);
    tbl[11] = mk(32'h80, 1, 32'h80, 1, 32'h300, 1, 32'h200, 0, 1, 1, 32'h200, 1, 32'h300, 16'd6);
    tbl[12] = mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h300, 0, 32'h300, 16'd6);
    tbl[13] = mk(32'h80, 1, 32'h40, 1, 32'h500, 0, 32'h44,  1, 1, 1, 32'h300, 1, 32'h500, 16'd7);
    tbl[14] = mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h84,  0, 32'h500, 16'd7);
    tbl[15] = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h44,  0, 32'h500, 16'd7);
    tbl[16] = mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1000, 0, 0, 0, 32'h0, 1, 32'h0, 16'd8);
    tbl[17] = mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 16'd8);
    tbl[18] = mk(32'h40, 0, 32'h40, 1, 32'h900, 0, 32'h44,  0, 0, 0, 32'h44,  0, 32'h0,   16'd8);

    rst_n = 1'b0;
    do_reset();

    // Directed table
    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // Mispredict counter saturation (not-taken miss: table unchanged)
    res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b1; res_pred_target = 32'h100; flush_btb = 1'b0;
    repeat (65534 - 8) @(posedge clk);
    #1 chk("mc_before_sat", 64'(mispred_count), 64'hFFFE);
    @(posedge clk); #1 chk("mc_at_sat", 64'(mispred_count), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1 chk("mc_held_sat", 64'(mispred_count), 64'hFFFF);
    chk("rv_during_sat", 64'(redirect_valid), 64'h1);

    // Async reset with a redirect showing and an allocated entry
    res_pc = 32'h40; res_taken = 1'b1; res_target = 32'h100;
    res_pred_taken = 1'b0; res_pred_target = 32'h44; fetch_pc = 32'h40;
    @(posedge clk); #1;
    chk("pre_rst_rv",  64'(redirect_valid), 64'h1);
    chk("pre_rst_hit", 64'(pred_hit), 64'h1);
    res_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rv",  64'(redirect_valid), 64'h0);
    chk("rst_rpc", 64'(redirect_pc), 64'h0);
    chk("rst_mc",  64'(mispred_count), 64'h0);
    chk("rst_hit", 64'(pred_hit), 64'h0);
    chk("rst_tgt", 64'(pred_target), 64'h44);
    @(posedge clk); #1 rst_n = 1'b1;
    // Mispredict in flight when reset hits again: must be cancelled
    res_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_pending_rv", 64'(redirect_valid), 64'h0);
    rst_n = 1'b1; res_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rv", 64'(redirect_valid), 64'h0);
    chk("post_rst_mc", 64'(mispred_count), 64'h0);

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      v.fetch_pc = rand_pc();
      v.rv  = ($urandom_range(0, 9) < 6);
      v.rpc = rand_pc();
      v.rt  = $urandom_range(0, 1);
      v.rtgt = ($urandom_range(0, 3) == 0) ? $urandom() : rand_pc();
      model_pred(v.rpc, ph, pt, ptg);
      if ($urandom_range(0, 3) != 0) begin
        v.pt = pt; v.ptgt = ptg;
      end else begin
        v.pt = $urandom_range(0, 1); v.ptgt = rand_pc();
      end
      v.fl = ($urandom_range(0, 49) == 0);
      v.e_hit = 0; v.e_taken = 0; v.e_tgt = '0; v.e_rv = 0; v.e_rpc = '0; v.e_mc = '0;
      model_step(v, w);
      apply(w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
